// File: rtl/puzzle_game_ctrl.sv
// -----------------------------------------------------------------------------
// puzzle_game_ctrl
//
// Top-level sequencer for the 2x2 sliding-puzzle datapath. Converts debounced
// push-button levels into the game phase code, single-cycle one-hot move
// pulses and the preset board word loaded by the puzzle engine. It also counts
// the moves of the current game and times the win display.
//
// FSM states (o_game_status encoding):
//   state           | meaning
//   ST_CHOSE_BOARD  | 00: idle, btn_sel cycles the preset, btn_start begins
//   ST_GAMING       | 01: direction edges become act pulses, watch win_flag
//   ST_GAME_INITIAL | 10: 2-cycle settle while the engine loads the board
//   ST_WINNED       | 11: win display for WIN_HOLD cycles or until btn_start
//
// Ports:
//   i_clk_d          divided system clock, all state on the rising edge
//   i_rst_n          asynchronous active-low reset
//   i_btn_start      debounced level: start / abort / skip win display
//   i_btn_sel        debounced level: cycle the preset board
//   i_btn_dir[3:0]   debounced levels: [0] up, [1] right, [2] down, [3] left
//   i_win_flag       registered solved indication from the engine
//   o_game_status    phase code, see table above
//   o_act[3:0]       one-hot move pulse, one cycle wide
//   o_origin_board   preset board selected by o_board_idx (one cycle later)
//   o_board_idx      current preset index
//   o_move_cnt       moves issued in the current game, saturating at 1023
// -----------------------------------------------------------------------------
module puzzle_game_ctrl #(
    parameter int unsigned WIN_HOLD = 1000,
    parameter logic [11:0] BOARD0   = 12'b000_001_010_011,
    parameter logic [11:0] BOARD1   = 12'b001_000_011_010,
    parameter logic [11:0] BOARD2   = 12'b010_011_000_001,
    parameter logic [11:0] BOARD3   = 12'b011_010_001_000
) (
    input  logic        i_clk_d,
    input  logic        i_rst_n,
    input  logic        i_btn_start,
    input  logic        i_btn_sel,
    input  logic [3:0]  i_btn_dir,
    input  logic        i_win_flag,
    output logic [1:0]  o_game_status,
    output logic [3:0]  o_act,
    output logic [11:0] o_origin_board,
    output logic [1:0]  o_board_idx,
    output logic [9:0]  o_move_cnt
);

    typedef enum logic [1:0] {
        ST_CHOSE_BOARD  = 2'b00,
        ST_GAMING       = 2'b01,
        ST_GAME_INITIAL = 2'b10,
        ST_WINNED       = 2'b11
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(WIN_HOLD - 1);
    localparam logic [9:0]  CNT_MAX   = 10'd1023;
    localparam logic [1:0]  COOL_LEN  = 2'd2;

    // -------------------------------------------------------------------------
    // Button edge detection
    // -------------------------------------------------------------------------
    logic       r_start_q;
    logic       r_sel_q;
    logic [3:0] r_dir_q;
    // Low for the first cycle after reset release so that a button held
    // through reset is only captured into the history registers, never seen
    // as a fresh press.
    logic       r_armed;

    logic       w_start_e;
    logic       w_sel_e;
    logic [3:0] w_dir_e;

    always_ff @(posedge i_clk_d or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start_q <= 1'b0;
            r_sel_q   <= 1'b0;
            r_dir_q   <= 4'b0000;
            r_armed   <= 1'b0;
        end else begin
            r_start_q <= i_btn_start;
            r_sel_q   <= i_btn_sel;
            r_dir_q   <= i_btn_dir;
            r_armed   <= 1'b1;
        end
    end

    assign w_start_e = r_armed & i_btn_start & ~r_start_q;
    assign w_sel_e   = r_armed & i_btn_sel   & ~r_sel_q;
    assign w_dir_e   = {4{r_armed}} & i_btn_dir & ~r_dir_q;

    // Lowest set bit wins among simultaneous direction edges.
    logic [3:0] w_act_sel;

    always_comb begin
        w_act_sel = 4'b0000;
        if (w_dir_e[0]) begin
            w_act_sel = 4'b0001;
        end else if (w_dir_e[1]) begin
            w_act_sel = 4'b0010;
        end else if (w_dir_e[2]) begin
            w_act_sel = 4'b0100;
        end else if (w_dir_e[3]) begin
            w_act_sel = 4'b1000;
        end
    end

    // -------------------------------------------------------------------------
    // Game sequencer
    // -------------------------------------------------------------------------
    state_t      r_state;
    logic [3:0]  r_act;
    logic [1:0]  r_board_idx;
    logic [9:0]  r_move_cnt;
    logic [1:0]  r_cool;       // cycles left in which direction edges are dropped
    logic        r_init_cnt;   // GAME_INITIAL down-counter, terminal count 0
    logic [15:0] r_hold;       // WINNED up-counter, leaves at HOLD_LAST

    always_ff @(posedge i_clk_d or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_CHOSE_BOARD;
            r_act       <= 4'b0000;
            r_board_idx <= 2'd0;
            r_move_cnt  <= 10'd0;
            r_cool      <= 2'd0;
            r_init_cnt  <= 1'b0;
            r_hold      <= 16'd0;
        end else begin
            r_act <= 4'b0000;
            case (r_state)
                ST_CHOSE_BOARD: begin
                    if (w_start_e) begin
                        r_state    <= ST_GAME_INITIAL;
                        r_move_cnt <= 10'd0;
                        r_init_cnt <= 1'b1;
                    end else if (w_sel_e) begin
                        r_board_idx <= r_board_idx + 2'd1;
                    end
                end

                ST_GAME_INITIAL: begin
                    if (r_init_cnt == 1'b0) begin
                        r_state <= ST_GAMING;
                        r_cool  <= 2'd0;
                    end else begin
                        r_init_cnt <= r_init_cnt - 1'b1;
                    end
                end

                ST_GAMING: begin
                    if (w_start_e) begin
                        r_state <= ST_CHOSE_BOARD;
                        r_cool  <= 2'd0;
                    end else if (r_cool != 2'd0) begin
                        // Edges and win_flag are not acted on here; win_flag is
                        // a level, so it is picked up once the cooldown ends.
                        r_cool <= r_cool - 2'd1;
                    end else if (i_win_flag) begin
                        r_state <= ST_WINNED;
                        r_hold  <= 16'd0;
                    end else if (w_dir_e != 4'b0000) begin
                        r_act  <= w_act_sel;
                        r_cool <= COOL_LEN;
                        if (r_move_cnt != CNT_MAX) begin
                            r_move_cnt <= r_move_cnt + 10'd1;
                        end
                    end
                end

                ST_WINNED: begin
                    if (w_start_e || (r_hold == HOLD_LAST)) begin
                        r_state <= ST_CHOSE_BOARD;
                        r_hold  <= 16'd0;
                    end else begin
                        r_hold <= r_hold + 16'd1;
                    end
                end

                default: begin
                    r_state <= ST_CHOSE_BOARD;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Preset board register, follows the index one cycle later
    // -------------------------------------------------------------------------
    logic [11:0] r_origin_board;

    always_ff @(posedge i_clk_d or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_origin_board <= BOARD0;
        end else begin
            case (r_board_idx)
                2'd0:    r_origin_board <= BOARD0;
                2'd1:    r_origin_board <= BOARD1;
                2'd2:    r_origin_board <= BOARD2;
                default: r_origin_board <= BOARD3;
            endcase
        end
    end

    assign o_game_status  = r_state;
    assign o_act          = r_act;
    assign o_origin_board = r_origin_board;
    assign o_board_idx    = r_board_idx;
    assign o_move_cnt     = r_move_cnt;

endmodule

// File: tb/tb_puzzle_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_puzzle_game_ctrl
//
// Cycle-level bench for puzzle_game_ctrl with WIN_HOLD = 4. Each vector holds
// the button levels driven during one cycle and the outputs expected in the
// following cycle. Expected records go through a scoreboard queue and are
// compared #1 after the rising edge.
// -----------------------------------------------------------------------------
module tb_puzzle_game_ctrl;

    localparam logic [11:0] B0 = 12'b000_001_010_011;
    localparam logic [11:0] B1 = 12'b001_000_011_010;
    localparam logic [11:0] B2 = 12'b010_011_000_001;
    localparam logic [11:0] B3 = 12'b011_010_001_000;

    logic        clk;
    logic        rst_n;
    logic        btn_start;
    logic        btn_sel;
    logic [3:0]  btn_dir;
    logic        win_flag;
    logic [1:0]  game_status;
    logic [3:0]  act;
    logic [11:0] origin_board;
    logic [1:0]  board_idx;
    logic [9:0]  move_cnt;

    puzzle_game_ctrl #(.WIN_HOLD(4)) dut (
        .i_clk_d        (clk),
        .i_rst_n        (rst_n),
        .i_btn_start    (btn_start),
        .i_btn_sel      (btn_sel),
        .i_btn_dir      (btn_dir),
        .i_win_flag     (win_flag),
        .o_game_status  (game_status),
        .o_act          (act),
        .o_origin_board (origin_board),
        .o_board_idx    (board_idx),
        .o_move_cnt     (move_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       sel;
        logic [3:0] dir;
        logic       win;
        logic [1:0] st;
        logic [3:0] act;
        logic [1:0] idx;
        logic [1:0] bidx;
        logic [9:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [11:0] board_of(input logic [1:0] i);
        case (i)
            2'd0:    return B0;
            2'd1:    return B1;
            2'd2:    return B2;
            default: return B3;
        endcase
    endfunction

    function automatic vec_t mk(input logic s, input logic sl, input logic [3:0] d,
                                input logic w, input logic [1:0] st,
                                input logic [3:0] a, input logic [1:0] ix,
                                input logic [1:0] bx, input logic [9:0] c);
        vec_t v;
        v.start = s;  v.sel = sl; v.dir = d;  v.win  = w;
        v.st    = st; v.act = a;  v.idx = ix; v.bidx = bx; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string name, input int id,
                       input logic [11:0] got, input logic [11:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s #%0d: got %b, expected %b", name, id, got, want);
        end
    endtask

    task automatic apply(input vec_t v, input string tag, input int id);
        vec_t e;
        sb.push_back(v);
        btn_start = v.start;
        btn_sel   = v.sel;
        btn_dir   = v.dir;
        win_flag  = v.win;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".status"}, id, {10'd0, game_status}, {10'd0, e.st});
        chk({tag, ".act"},    id, {8'd0, act},          {8'd0, e.act});
        chk({tag, ".idx"},    id, {10'd0, board_idx},   {10'd0, e.idx});
        chk({tag, ".board"},  id, origin_board,         board_of(e.bidx));
        chk({tag, ".cnt"},    id, {2'd0, move_cnt},     {2'd0, e.cnt});
    endtask

    initial begin
        logic [3:0] pat;
        logic [3:0] low;
        logic [9:0] ecnt;

        rst_n = 1'b0; btn_start = 1'b0; btn_sel = 1'b0; btn_dir = 4'b0; win_flag = 1'b0;

        //            start sel  dir     win st     act     idx  bidx cnt
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b00, 4'b0000, 2'd0, 2'd0, 10'd0)); // 0 idle
        tbl.push_back(mk(0, 1, 4'b0000, 0, 2'b00, 4'b0000, 2'd1, 2'd0, 10'd0)); // 1 sel
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b00, 4'b0000, 2'd1, 2'd1, 10'd0));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 2'b00, 4'b0000, 2'd2, 2'd1, 10'd0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b00, 4'b0000, 2'd2, 2'd2, 10'd0));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 2'b00, 4'b0000, 2'd3, 2'd2, 10'd0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b00, 4'b0000, 2'd3, 2'd3, 10'd0));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 2'b00, 4'b0000, 2'd0, 2'd3, 10'd0)); // 7 wrap
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b00, 4'b0000, 2'd0, 2'd0, 10'd0));
        tbl.push_back(mk(1, 1, 4'b0000, 0, 2'b10, 4'b0000, 2'd0, 2'd0, 10'd0)); // 9 start wins over sel
        tbl.push_back(mk(0, 0, 4'b0001, 0, 2'b10, 4'b0000, 2'd0, 2'd0, 10'd0)); // 10 dir ignored in init
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd0)); // 11 gaming
        tbl.push_back(mk(0, 0, 4'b0110, 0, 2'b01, 4'b0010, 2'd0, 2'd0, 10'd1)); // 12 priority
        tbl.push_back(mk(0, 0, 4'b0111, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd1)); // 13 dropped
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd1));
        tbl.push_back(mk(0, 0, 4'b1000, 0, 2'b01, 4'b1000, 2'd0, 2'd0, 10'd2)); // 15 earliest next
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd2));
        tbl.push_back(mk(0, 0, 4'b0001, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd2)); // 17 dropped
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd2));
        tbl.push_back(mk(0, 0, 4'b0100, 0, 2'b01, 4'b0100, 2'd0, 2'd0, 10'd3));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd3)); // 20 win in cooldown
        tbl.push_back(mk(0, 0, 4'b0000, 1, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd3));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 2'b11, 4'b0000, 2'd0, 2'd0, 10'd3)); // 22 winned
        tbl.push_back(mk(0, 0, 4'b0001, 0, 2'b11, 4'b0000, 2'd0, 2'd0, 10'd3)); // 23 frozen
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b11, 4'b0000, 2'd0, 2'd0, 10'd3));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b11, 4'b0000, 2'd0, 2'd0, 10'd3));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b00, 4'b0000, 2'd0, 2'd0, 10'd3)); // 26 hold over
        tbl.push_back(mk(1, 0, 4'b0000, 0, 2'b10, 4'b0000, 2'd0, 2'd0, 10'd0)); // 27 cnt cleared
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b10, 4'b0000, 2'd0, 2'd0, 10'd0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd0));
        tbl.push_back(mk(0, 0, 4'b0010, 0, 2'b01, 4'b0010, 2'd0, 2'd0, 10'd1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd1));
        tbl.push_back(mk(1, 0, 4'b0010, 0, 2'b00, 4'b0000, 2'd0, 2'd0, 10'd1)); // 34 abort > dir
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2'b00, 4'b0000, 2'd0, 2'd0, 10'd1));

        repeat (3) @(posedge clk);
        #1;
        chk("rst.status", 0, {10'd0, game_status}, 12'd0);
        chk("rst.act",    0, {8'd0, act},          12'd0);
        chk("rst.idx",    0, {10'd0, board_idx},   12'd0);
        chk("rst.board",  0, origin_board,         B0);
        chk("rst.cnt",    0, {2'd0, move_cnt},     12'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], "tbl", i);
        end

        // Saturation of move_cnt with a rotating set of simultaneous edges.
        apply(mk(1, 0, 4'b0000, 0, 2'b10, 4'b0000, 2'd0, 2'd0, 10'd0), "sat", 0);
        apply(mk(0, 0, 4'b0000, 0, 2'b10, 4'b0000, 2'd0, 2'd0, 10'd0), "sat", 1);
        apply(mk(0, 0, 4'b0000, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd0), "sat", 2);
        for (int i = 0; i < 1030; i++) begin
            pat  = 4'((i % 15) + 1);
            low  = pat & (~pat + 4'd1);
            ecnt = (i + 1 < 1023) ? 10'(i + 1) : 10'd1023;
            apply(mk(0, 0, pat,     0, 2'b01, low,     2'd0, 2'd0, ecnt), "satp", i);
            apply(mk(0, 0, 4'b0000, 0, 2'b01, 4'b0000, 2'd0, 2'd0, ecnt), "satc", i);
            apply(mk(0, 0, 4'b0000, 0, 2'b01, 4'b0000, 2'd0, 2'd0, ecnt), "satc", i);
        end

        // Early start during the win display.
        apply(mk(0, 0, 4'b0000, 1, 2'b11, 4'b0000, 2'd0, 2'd0, 10'd1023), "wskip", 0);
        apply(mk(1, 0, 4'b0000, 0, 2'b00, 4'b0000, 2'd0, 2'd0, 10'd1023), "wskip", 1);
        apply(mk(0, 0, 4'b0000, 0, 2'b00, 4'b0000, 2'd0, 2'd0, 10'd1023), "wskip", 2);

        // Reset asserted while act is high, buttons held through release.
        apply(mk(1, 0, 4'b0000, 0, 2'b10, 4'b0000, 2'd0, 2'd0, 10'd0), "mrst", 0);
        apply(mk(0, 0, 4'b0000, 0, 2'b10, 4'b0000, 2'd0, 2'd0, 10'd0), "mrst", 1);
        apply(mk(0, 0, 4'b0000, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd0), "mrst", 2);
        apply(mk(0, 0, 4'b0100, 0, 2'b01, 4'b0100, 2'd0, 2'd0, 10'd1), "mrst", 3);
        rst_n = 1'b0;
        #1;
        chk("arst.act",    0, {8'd0, act},          12'd0);
        chk("arst.cnt",    0, {2'd0, move_cnt},     12'd0);
        chk("arst.status", 0, {10'd0, game_status}, 12'd0);
        btn_start = 1'b1;
        btn_dir   = 4'b0100;
        #1;
        rst_n = 1'b1;
        apply(mk(1, 0, 4'b0100, 0, 2'b00, 4'b0000, 2'd0, 2'd0, 10'd0), "rel", 0);
        apply(mk(0, 0, 4'b0100, 0, 2'b00, 4'b0000, 2'd0, 2'd0, 10'd0), "rel", 1);
        apply(mk(1, 0, 4'b0100, 0, 2'b10, 4'b0000, 2'd0, 2'd0, 10'd0), "rel", 2);
        apply(mk(0, 0, 4'b0100, 0, 2'b10, 4'b0000, 2'd0, 2'd0, 10'd0), "rel", 3);
        apply(mk(0, 0, 4'b0100, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd0), "rel", 4);
        apply(mk(0, 0, 4'b0100, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd0), "rel", 5);
        apply(mk(0, 0, 4'b0000, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd0), "rel", 6);
        apply(mk(0, 0, 4'b0100, 0, 2'b01, 4'b0100, 2'd0, 2'd0, 10'd1), "rel", 7);
        apply(mk(0, 0, 4'b0000, 0, 2'b01, 4'b0000, 2'd0, 2'd0, 10'd1), "rel", 8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
